// File: rtl/mmr_pkg.sv
// rtl/mmr_pkg.sv - shared address decode and sizing for the mmr_bank register bank
package mmr_pkg;

    localparam int MAX_COUNT = 64;
    localparam int IDX_W     = $clog2(MAX_COUNT);

    typedef struct packed {
        logic             hit;
        logic [IDX_W-1:0] idx;
    } mmr_dec_t;

    // Offset is taken at 32 bits so BASE near the top of the map cannot wrap into a false hit.
    function automatic mmr_dec_t mmr_decode(input logic [31:0] addr,
                                            input logic [31:0] base,
                                            input int          count);
        logic [31:0] off;
        mmr_dec_t    r;
        off   = addr - base;
        r.hit = (addr >= base) && (off < 32'(count));
        r.idx = off[IDX_W-1:0];
        return r;
    endfunction

endpackage

// File: rtl/mmr_cell.sv
// rtl/mmr_cell.sv - one bank register with bus/peripheral/read-clear priority (read-clear under MMR_BANK_RDCLR_EN)
module mmr_cell #(
    parameter int               WIDTH     = 32,
    parameter logic [WIDTH-1:0] RESET_VAL = '0,
    parameter bit               RO        = 1'b0,
    parameter bit               RDCLR     = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             bus_we,
    input  logic             bus_rd,
    input  logic [WIDTH-1:0] bus_d,
    input  logic             hw_we,
    input  logic [WIDTH-1:0] hw_d,
    output logic [WIDTH-1:0] q
);

`ifdef MMR_BANK_RDCLR_EN
    localparam bit CLR_EN = 1'b1;
`else
    localparam bit CLR_EN = 1'b0;
`endif

    // A read-only register ignores bus writes entirely, so a peripheral load still lands.
    always_ff @(posedge clk) begin
        if (reset) begin
            q <= RESET_VAL;
        end else if (bus_we && !RO) begin
            q <= bus_d;
        end else if (hw_we) begin
            q <= hw_d;
        end else if (bus_rd && RDCLR && CLR_EN) begin
            q <= '0;
        end
    end

endmodule

// File: rtl/mmr_bank.sv
// rtl/mmr_bank.sv - COUNT-register memory-mapped bank with registered response (MMR_BANK_RDCLR_EN enables read-clear)
`ifndef VIDEO_ADDR
`define VIDEO_ADDR 32'h0000_0100
`endif

module mmr_bank #(
    parameter logic [31:0]      BASE       = `VIDEO_ADDR,
    parameter int               COUNT      = 4,
    parameter int               WIDTH      = 32,
    parameter logic [WIDTH-1:0] RESET_VAL  = '0,
    parameter logic [COUNT-1:0] RO_MASK    = '0,
    parameter logic [COUNT-1:0] RDCLR_MASK = '0
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   enable,
    input  logic                   rw,
    input  logic [31:0]            addr,
    input  logic [31:0]            d_in,
    output logic [31:0]            d_out,
    output logic                   ack,
    input  logic [COUNT-1:0]       hw_we,
    input  logic [COUNT*WIDTH-1:0] hw_d,
    output logic [COUNT*WIDTH-1:0] q,
    output logic [COUNT-1:0]       wr_stb,
    output logic [COUNT-1:0]       rd_stb
);
    import mmr_pkg::*;

    mmr_dec_t         dec;
    logic             hit;
    logic [COUNT-1:0] sel;
    logic [COUNT-1:0] wr_sel;
    logic [COUNT-1:0] rd_sel;
    logic [WIDTH-1:0] rd_val;

    assign dec    = mmr_decode(addr, BASE, COUNT);
    assign hit    = enable && dec.hit;
    assign wr_sel = sel & {COUNT{rw}};
    assign rd_sel = sel & {COUNT{!rw}};

    always_comb begin
        sel    = '0;
        rd_val = '0;
        for (int i = 0; i < COUNT; i++) begin
            if (hit && dec.idx == IDX_W'(i)) begin
                sel[i] = 1'b1;
                rd_val = q[i*WIDTH +: WIDTH];
            end
        end
    end

    for (genvar i = 0; i < COUNT; i++) begin : g_cell
        mmr_cell #(
            .WIDTH     (WIDTH),
            .RESET_VAL (RESET_VAL),
            .RO        (RO_MASK[i]),
            .RDCLR     (RDCLR_MASK[i])
        ) u_cell (
            .clk    (clk),
            .reset  (reset),
            .bus_we (wr_sel[i]),
            .bus_rd (rd_sel[i]),
            .bus_d  (d_in[WIDTH-1:0]),
            .hw_we  (hw_we[i]),
            .hw_d   (hw_d[i*WIDTH +: WIDTH]),
            .q      (q[i*WIDTH +: WIDTH])
        );
    end

    // rd_val is sampled from q before the edge, so a same-cycle load or clear returns the old value.
    always_ff @(posedge clk) begin
        if (reset) begin
            ack    <= 1'b0;
            d_out  <= '0;
            wr_stb <= '0;
            rd_stb <= '0;
        end else begin
            ack    <= hit;
            d_out  <= (hit && !rw) ? 32'(rd_val) : 32'h0;
            wr_stb <= wr_sel & ~RO_MASK;
            rd_stb <= rd_sel;
        end
    end

endmodule

// File: tb/tb_mmr_bank.sv
// tb/tb_mmr_bank.sv - randomized reference-model bench for mmr_bank (honours MMR_BANK_RDCLR_EN)
module tb_mmr_bank;

    localparam logic [31:0] BASE  = 32'h0000_1000;
    localparam logic [7:0]  RVAL  = 8'h5A;
    localparam logic [3:0]  RO    = 4'b0001;
    localparam logic [3:0]  RDCLR = 4'b1000;
`ifdef MMR_BANK_RDCLR_EN
    localparam bit RDCLR_EN = 1'b1;
`else
    localparam bit RDCLR_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b0;
    logic        rw = 1'b0;
    logic [31:0] addr = '0;
    logic [31:0] d_in = '0;
    logic [31:0] d_out;
    logic        ack;
    logic [3:0]  hw_we = '0;
    logic [31:0] hw_d = '0;
    logic [31:0] q;
    logic [3:0]  wr_stb;
    logic [3:0]  rd_stb;

    int n_checks = 0;
    int n_fail   = 0;
    logic [7:0] m [4];

    always #5 clk = ~clk;

    mmr_bank #(
        .BASE       (BASE),
        .COUNT      (4),
        .WIDTH      (8),
        .RESET_VAL  (RVAL),
        .RO_MASK    (RO),
        .RDCLR_MASK (RDCLR)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .enable (enable),
        .rw     (rw),
        .addr   (addr),
        .d_in   (d_in),
        .d_out  (d_out),
        .ack    (ack),
        .hw_we  (hw_we),
        .hw_d   (hw_d),
        .q      (q),
        .wr_stb (wr_stb),
        .rd_stb (rd_stb)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // One bus cycle: drive, predict from the register-bank rules, clock, compare.
    task automatic step(input logic en, input logic w, input logic [31:0] a, input logic [31:0] din,
                        input logic [3:0] hwe, input logic [31:0] hd, input logic rst);
        logic        hit;
        int          idx;
        logic        e_ack;
        logic [31:0] e_dout;
        logic [3:0]  e_wr, e_rd;
        logic [7:0]  nm [4];
        enable = en; rw = w; addr = a; d_in = din; hw_we = hwe; hw_d = hd; reset = rst;
        hit = en && (a >= BASE) && (a < BASE + 32'd4);
        idx = hit ? int'(a - BASE) : 0;
        e_ack = 1'b0; e_dout = 32'h0; e_wr = 4'h0; e_rd = 4'h0;
        for (int i = 0; i < 4; i++) nm[i] = m[i];
        if (rst) begin
            for (int i = 0; i < 4; i++) nm[i] = RVAL;
        end else begin
            e_ack = hit;
            if (hit && !w) begin
                e_dout = {24'h0, m[idx]};
                e_rd   = 4'(1 << idx);
            end
            if (hit && w && !RO[idx]) e_wr = 4'(1 << idx);
            for (int i = 0; i < 4; i++) begin
                if (hit && w && idx == i && !RO[i])                 nm[i] = din[7:0];
                else if (hwe[i])                                    nm[i] = hd[i*8 +: 8];
                else if (RDCLR_EN && hit && !w && idx == i && RDCLR[i]) nm[i] = 8'h00;
            end
        end
        for (int i = 0; i < 4; i++) m[i] = nm[i];
        @(posedge clk);
        #1;
        check("ack", {31'h0, ack}, {31'h0, e_ack});
        check("d_out", d_out, e_dout);
        check("wr_stb", {28'h0, wr_stb}, {28'h0, e_wr});
        check("rd_stb", {28'h0, rd_stb}, {28'h0, e_rd});
        check("q", q, {m[3], m[2], m[1], m[0]});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 4; i++) m[i] = 8'h00;
        step(0, 0, 32'h0, 32'h0, 4'h0, 32'h0, 1);
        step(0, 0, 32'h0, 32'h0, 4'h0, 32'h0, 1);
        check("reset_q", q, 32'h5A5A5A5A);
        check("reset_ack", {31'h0, ack}, 32'h0);

        step(1, 1, BASE + 2, 32'h1234_56AB, 4'h0, 32'h0, 0);
        check("wr_stb_reg2", {28'h0, wr_stb}, 32'h4);
        step(1, 0, BASE + 2, 32'h0, 4'h0, 32'h0, 0);
        check("rd_reg2", d_out, 32'h0000_00AB);
        step(0, 0, 32'h0, 32'h0, 4'h0, 32'h0, 0);
        check("d_out_idle", d_out, 32'h0);

        step(1, 1, BASE + 4, 32'hDEAD_BEEF, 4'h0, 32'h0, 0);
        step(1, 1, BASE - 1, 32'hDEAD_BEEF, 4'h0, 32'h0, 0);
        check("miss_ack", {31'h0, ack}, 32'h0);

        step(1, 1, BASE, 32'h77, 4'b0001, 32'h0000_0011, 0);
        check("ro_wr_stb", {28'h0, wr_stb}, 32'h0);
        check("ro_reg0", {24'h0, q[7:0]}, 32'h11);
        step(1, 1, BASE + 1, 32'h0000_00C3, 4'b0010, 32'h0000_3C00, 0);
        check("bus_beats_hw", {24'h0, q[15:8]}, 32'hC3);

        step(0, 0, 32'h0, 32'h0, 4'b1000, 32'hF000_0000, 0);
        step(1, 0, BASE + 3, 32'h0, 4'h0, 32'h0, 0);
        check("rdclr_dout", d_out, 32'hF0);
        check("rdclr_q3", {24'h0, q[31:24]}, RDCLR_EN ? 32'h00 : 32'hF0);
        step(0, 0, 32'h0, 32'h0, 4'b1000, 32'hF000_0000, 0);
        step(1, 0, BASE + 3, 32'h0, 4'b1000, 32'h0100_0000, 0);
        check("rdclr_hw_dout", d_out, 32'hF0);
        check("rdclr_hw_q3", {24'h0, q[31:24]}, 32'h01);

        step(1, 0, BASE + 0, 32'h0, 4'h0, 32'h0, 0);
        step(1, 0, BASE + 1, 32'h0, 4'h0, 32'h0, 0);
        step(1, 0, BASE + 2, 32'h0, 4'h0, 32'h0, 1);
        check("mid_reset_q", q, 32'h5A5A5A5A);
        step(1, 0, BASE + 3, 32'h0, 4'h0, 32'h0, 0);
        step(0, 0, 32'h0, 32'h0, 4'h0, 32'h0, 0);

        for (int n = 0; n < 400; n++) begin
            step(($urandom % 4) != 0, $urandom % 2, BASE - 2 + ($urandom % 8), $urandom,
                 (($urandom % 4) == 0) ? 4'($urandom % 16) : 4'h0, $urandom,
                 ($urandom % 50) == 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
